// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI command sequencer.
// Latency: none (definitions only).
// Backpressure: not applicable.
package spi_seq_pkg;

  // Operation types carried in the command word.
  localparam logic [1:0] OP_W   = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_R   = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } seq_state_e;

  // Command word layout: {opt[35:34], nwr[33:29], nrd[28:24], data[23:0]}.
  localparam int CMD_W    = 36;
  localparam int OPT_LSB  = 34;
  localparam int NWR_LSB  = 29;
  localparam int NRD_LSB  = 24;
  localparam int DATA_LSB = 0;

  typedef struct packed {
    logic [1:0]  opt;
    logic [4:0]  nwr;
    logic [4:0]  nrd;
    logic [23:0] data;
  } cmd_t;

  // Read word returned when the interface never acknowledges a launch.
  localparam logic [23:0] TIMEOUT_FILL = 24'hDEAD00;

  // Assemble a command word from its fields.
  function automatic logic [CMD_W-1:0] pack_cmd(input logic [1:0] opt, input logic [4:0] nwr,
                                                input logic [4:0] nrd, input logic [23:0] data);
    logic [CMD_W-1:0] w;
    w = '0;
    w[OPT_LSB +: 2]   = opt;
    w[NWR_LSB +: 5]   = nwr;
    w[NRD_LSB +: 5]   = nrd;
    w[DATA_LSB +: 24] = data;
    return w;
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO for queued SPI commands.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: pushes while full are dropped; pops while empty are ignored.
module spi_cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                     SCLK,
  input  logic                     RST_N,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign full_o     = (level_o == (AW+1)'(DEPTH));
  assign empty_o    = (level_o == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance read/write pointers on accepted push and pop.
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge SCLK) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/spi_cmd_seq.sv
// Command sequencer: queues SPI transactions and launches them one at a time.
// Latency: launch two cycles after push into an empty queue; optional macro SPI_SEQ_TIMEOUT_EN.
// Backpressure: CMD_READY low when queue full; pending response blocks the next launch.
module spi_cmd_seq
  import spi_seq_pkg::*;
#(
  parameter int CMD_DEPTH   = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        SCLK,
  input  logic                        RST_N,
  input  logic                        CMD_VALID,
  output logic                        CMD_READY,
  input  logic [1:0]                  CMD_OPT,
  input  logic [4:0]                  CMD_NWR,
  input  logic [4:0]                  CMD_NRD,
  input  logic [23:0]                 CMD_DATA,
  output logic                        RSP_VALID,
  input  logic                        RSP_READY,
  output logic [23:0]                 RSP_DATA,
  output logic                        SPI_START,
  output logic [1:0]                  SPI_OPT,
  output logic [4:0]                  SPI_NWR,
  output logic [4:0]                  SPI_NRD,
  output logic [23:0]                 SPI_DATA,
  input  logic                        SPI_BUSY,
  input  logic [23:0]                 SPI_RDATA,
  output logic                        SEQ_IDLE,
  output logic [$clog2(CMD_DEPTH):0]  CMD_LEVEL,
  output logic                        ERR_TIMEOUT
);

  // Reject unsupported parameter values at elaboration.
  if (CMD_DEPTH < 2 || CMD_DEPTH > 32 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("CMD_DEPTH must be a power of two in 2..32");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  seq_state_e        state_q;
  logic              spi_start_q;
  logic [1:0]        spi_opt_q;
  logic [4:0]        spi_nwr_q;
  logic [4:0]        spi_nrd_q;
  logic [23:0]       spi_data_q;
  logic              rsp_valid_q;
  logic [23:0]       rsp_data_q;

  logic [CMD_W-1:0]  head_raw;
  cmd_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_illegal;
  logic              launch;
  logic              fifo_pop;

  spi_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_fifo (
    .SCLK       (SCLK),
    .RST_N      (RST_N),
    .push_i     (CMD_VALID),
    .push_dat_i (pack_cmd(CMD_OPT, CMD_NWR, CMD_NRD, CMD_DATA)),
    .pop_i      (fifo_pop),
    .head_dat_o (head_raw),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (CMD_LEVEL)
  );

  assign head = cmd_t'(head_raw);

  // Illegal entries are dropped in IDLE regardless of BUSY; real ones wait for the interface.
  always_comb begin
    head_illegal = 1'b0;
    launch       = 1'b0;
    fifo_pop     = 1'b0;
    if (state_q == ST_IDLE && !fifo_empty) begin
      head_illegal = (head.opt == OP_ILL);
      launch       = !head_illegal && !SPI_BUSY;
      fifo_pop     = head_illegal || launch;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_q;
  logic          err_timeout_q;
  assign ERR_TIMEOUT = err_timeout_q;
`else
  assign ERR_TIMEOUT = 1'b0;
`endif

  // Sequencer FSM with registered interface and response outputs.
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      spi_start_q <= 1'b0;
      spi_opt_q   <= '0;
      spi_nwr_q   <= '0;
      spi_nrd_q   <= '0;
      spi_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            spi_opt_q   <= head.opt;
            spi_nwr_q   <= head.nwr;
            spi_nrd_q   <= head.nrd;
            spi_data_q  <= head.data;
            spi_start_q <= 1'b1;
            state_q     <= ST_LAUNCH;
`ifdef SPI_SEQ_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
          end
        end
        ST_LAUNCH: begin
          // START is held until BUSY is seen so a slow interface enable cannot miss it.
          if (SPI_BUSY) begin
            spi_start_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            spi_start_q   <= 1'b0;
            err_timeout_q <= 1'b1;
            if (spi_opt_q == OP_W) begin
              state_q <= ST_IDLE;
            end else begin
              rsp_data_q  <= TIMEOUT_FILL;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        ST_WAIT: begin
          if (!SPI_BUSY) begin
            if (spi_opt_q == OP_W) begin
              state_q <= ST_IDLE;
            end else begin
              rsp_data_q  <= SPI_RDATA;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CMD_READY = !fifo_full;
  assign SEQ_IDLE  = (state_q == ST_IDLE) && fifo_empty;
  assign SPI_START = spi_start_q;
  assign SPI_OPT   = spi_opt_q;
  assign SPI_NWR   = spi_nwr_q;
  assign SPI_NRD   = spi_nrd_q;
  assign SPI_DATA  = spi_data_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;

endmodule
